// File: rtl/game_flow_ctrl_if.sv
// Event and status bundle between the game sequencer and the rest of the Pac-Man datapath.
// Event pulses and keys flow toward the sequencer; state and counters flow back.
interface game_flow_ctrl_if;
  logic       startOfFrame;
  logic       start_key;
  logic       pause_key;
  logic       ghost_hit;
  logic       pellet_eaten;
  logic       playGame;
  logic       actors_restart;
  logic [2:0] lives;
  logic [3:0] level;
  logic [8:0] pellets_left;
  logic [2:0] game_state;

  modport master (
    output startOfFrame, start_key, pause_key, ghost_hit, pellet_eaten,
    input  playGame, actors_restart, lives, level, pellets_left, game_state
  );

  modport slave (
    input  startOfFrame, start_key, pause_key, ghost_hit, pellet_eaten,
    output playGame, actors_restart, lives, level, pellets_left, game_state
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Pac-Man game sequencer: state machine, lives/level/pellet tracking, mover enable and restart pulse.
// Optional pause support is compiled in with GAME_PAUSE_EN.
module game_flow_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int READY_FRAMES  = 60,
  parameter int DEATH_FRAMES  = 45,
  parameter int CLEAR_FRAMES  = 60,
  parameter int PELLETS_TOTAL = 240
) (
  input logic              clk,
  input logic              reset,
  game_flow_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_READY   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DYING   = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_OVER    = 3'd5,
    ST_PAUSED  = 3'd6
  } state_e;

  localparam logic [15:0] READY_LAST   = 16'(READY_FRAMES - 1);
  localparam logic [15:0] DEATH_LAST   = 16'(DEATH_FRAMES - 1);
  localparam logic [15:0] CLEAR_LAST   = 16'(CLEAR_FRAMES - 1);
  localparam logic [8:0]  PELLETS_LOAD = 9'(PELLETS_TOTAL);
  localparam logic [2:0]  LIVES_LOAD   = 3'(LIVES_INIT);

  state_e      state_q;
  logic [15:0] frame_q;
  logic [2:0]  lives_q;
  logic [3:0]  level_q;
  logic [8:0]  pellets_q;
  logic        play_q;
  logic        restart_q;

  // The arm bit keeps a key held through reset from looking like a fresh press.
  logic start_cur_q, start_prev_q, start_arm_q;
  logic start_rise;
  assign start_rise = start_cur_q & ~start_prev_q & start_arm_q;

`ifdef GAME_PAUSE_EN
  logic pause_cur_q, pause_prev_q, pause_arm_q;
  logic pause_rise;
  assign pause_rise = pause_cur_q & ~pause_prev_q & pause_arm_q;
`endif

  logic final_pellet;
  assign final_pellet = bus.pellet_eaten && (pellets_q == 9'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ATTRACT;
      frame_q      <= '0;
      lives_q      <= '0;
      level_q      <= '0;
      pellets_q    <= '0;
      play_q       <= 1'b0;
      restart_q    <= 1'b0;
      start_cur_q  <= 1'b0;
      start_prev_q <= 1'b0;
      start_arm_q  <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause_cur_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      pause_arm_q  <= 1'b0;
`endif
    end else begin
      start_cur_q  <= bus.start_key;
      start_prev_q <= start_cur_q;
      if (!bus.start_key) start_arm_q <= 1'b1;
`ifdef GAME_PAUSE_EN
      pause_cur_q  <= bus.pause_key;
      pause_prev_q <= pause_cur_q;
      if (!bus.pause_key) pause_arm_q <= 1'b1;
`endif
      restart_q <= 1'b0;
      play_q    <= (state_q == ST_PLAY);

      case (state_q)
        ST_ATTRACT: begin
          if (start_rise) begin
            lives_q   <= LIVES_LOAD;
            level_q   <= 4'd1;
            pellets_q <= PELLETS_LOAD;
            state_q   <= ST_READY;
            frame_q   <= '0;
            restart_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (bus.startOfFrame) begin
            if (frame_q == READY_LAST) begin
              state_q <= ST_PLAY;
              frame_q <= '0;
            end else begin
              frame_q <= frame_q + 16'd1;
            end
          end
        end
        ST_PLAY: begin
          if (bus.pellet_eaten && pellets_q != 9'd0) pellets_q <= pellets_q - 9'd1;
          // The last pellet outranks a same-cycle ghost hit.
          if (final_pellet) begin
            state_q <= ST_CLEAR;
            frame_q <= '0;
          end else if (bus.ghost_hit) begin
            if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
            state_q <= ST_DYING;
            frame_q <= '0;
          end
`ifdef GAME_PAUSE_EN
          else if (pause_rise) begin
            state_q <= ST_PAUSED;
            frame_q <= '0;
          end
`endif
        end
        ST_DYING: begin
          if (bus.startOfFrame) begin
            if (frame_q == DEATH_LAST) begin
              frame_q <= '0;
              if (lives_q == 3'd0) begin
                state_q <= ST_OVER;
              end else begin
                state_q   <= ST_READY;
                restart_q <= 1'b1;
              end
            end else begin
              frame_q <= frame_q + 16'd1;
            end
          end
        end
        ST_CLEAR: begin
          if (bus.startOfFrame) begin
            if (frame_q == CLEAR_LAST) begin
              if (level_q != 4'd15) level_q <= level_q + 4'd1;
              pellets_q <= PELLETS_LOAD;
              state_q   <= ST_READY;
              frame_q   <= '0;
              restart_q <= 1'b1;
            end else begin
              frame_q <= frame_q + 16'd1;
            end
          end
        end
        ST_OVER: begin
          if (start_rise) begin
            state_q <= ST_ATTRACT;
            frame_q <= '0;
          end
        end
`ifdef GAME_PAUSE_EN
        ST_PAUSED: begin
          if (pause_rise) begin
            state_q <= ST_PLAY;
            frame_q <= '0;
          end
        end
`endif
        default: begin
          state_q <= ST_ATTRACT;
          frame_q <= '0;
        end
      endcase
    end
  end

  assign bus.playGame       = play_q;
  assign bus.actors_restart = restart_q;
  assign bus.lives          = lives_q;
  assign bus.level          = level_q;
  assign bus.pellets_left   = pellets_q;
  assign bus.game_state     = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short timed states (READY 4, DYING 3, CLEAR 2 frames).
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(
    .LIVES_INIT    (3),
    .READY_FRAMES  (4),
    .DEATH_FRAMES  (3),
    .CLEAR_FRAMES  (2),
    .PELLETS_TOTAL (240)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic pellets(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pellet_eaten = 1'b1;
      tick();
      bus.pellet_eaten = 1'b0;
      tick();
    end
  endtask

  task automatic hit();
    bus.ghost_hit = 1'b1;
    tick();
    bus.ghost_hit = 1'b0;
  endtask

  task automatic press_start();
    bus.start_key = 1'b1;
    tick();
    tick();
  endtask

  task automatic release_start();
    bus.start_key = 1'b0;
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.start_key    = 1'b0;
    bus.pause_key    = 1'b0;
    bus.ghost_hit    = 1'b0;
    bus.pellet_eaten = 1'b0;
    tick();
    tick();
    check("rst_state",   bus.game_state, 0);
    check("rst_play",    bus.playGame, 0);
    check("rst_restart", bus.actors_restart, 0);
    check("rst_lives",   bus.lives, 0);
    check("rst_level",   bus.level, 0);
    check("rst_pellets", bus.pellets_left, 0);
    reset = 1'b0;
    tick();
    tick();

    // Game start
    press_start();
    check("start_state",   bus.game_state, 1);
    check("start_restart", bus.actors_restart, 1);
    check("start_lives",   bus.lives, 3);
    check("start_level",   bus.level, 1);
    check("start_pellets", bus.pellets_left, 240);
    release_start();
    check("restart_one_cycle", bus.actors_restart, 0);
    frames(3);
    check("ready_3rd_frame", bus.game_state, 1);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    check("ready_4th_frame", bus.game_state, 2);
    check("play_lag",        bus.playGame, 0);
    tick();
    check("play_on",         bus.playGame, 1);

    // Clear a full level
    pellets(239);
    check("pellets_one",  bus.pellets_left, 1);
    check("still_play",   bus.game_state, 2);
    pellets(1);
    check("clear_state",  bus.game_state, 4);
    check("clear_zero",   bus.pellets_left, 0);
    check("clear_play_off", bus.playGame, 0);
    hit();
    tick();
    check("hit_ignored_clear", bus.lives, 3);
    frames(1);
    check("clear_1st_frame", bus.game_state, 4);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    check("clear_exit_state",   bus.game_state, 1);
    check("clear_exit_restart", bus.actors_restart, 1);
    check("level_two",          bus.level, 2);
    check("pellets_reload",     bus.pellets_left, 240);
    tick();
    frames(4);
    check("play_lvl2", bus.game_state, 2);

    // Lose two lives
    hit();
    check("die1_state", bus.game_state, 3);
    check("die1_lives", bus.lives, 2);
    tick();
    frames(2);
    check("dying_2nd_frame", bus.game_state, 3);
    frames(1);
    check("die1_ready",   bus.game_state, 1);
    check("die1_pellets", bus.pellets_left, 240);
    frames(4);
    hit();
    check("die2_lives", bus.lives, 1);
    tick();
    frames(3);
    frames(4);
    check("play_lives1", bus.game_state, 2);

    // Final pellet beats simultaneous ghost hit
    pellets(239);
    check("sim_pre_pellets", bus.pellets_left, 1);
    bus.ghost_hit    = 1'b1;
    bus.pellet_eaten = 1'b1;
    tick();
    bus.ghost_hit    = 1'b0;
    bus.pellet_eaten = 1'b0;
    check("sim_state",   bus.game_state, 4);
    check("sim_lives",   bus.lives, 1);
    check("sim_pellets", bus.pellets_left, 0);
    tick();
    frames(2);
    check("level_three", bus.level, 3);
    frames(4);

    // Last life lost
    hit();
    check("die3_state", bus.game_state, 3);
    check("die3_lives", bus.lives, 0);
    tick();
    check("die3_play_off", bus.playGame, 0);
    frames(3);
    check("over_state",   bus.game_state, 5);
    check("over_level",   bus.level, 3);
    check("over_pellets", bus.pellets_left, 240);
    press_start();
    check("over_to_attract", bus.game_state, 0);
    release_start();

    // New game, then pause key
    press_start();
    check("new_game_lives", bus.lives, 3);
    check("new_game_level", bus.level, 1);
    release_start();
    frames(4);
    check("new_game_play", bus.game_state, 2);
    tick();
    bus.pause_key = 1'b1;
    tick();
    tick();
`ifdef GAME_PAUSE_EN
    check("pause_state", bus.game_state, 6);
    tick();
    check("pause_play_off", bus.playGame, 0);
    bus.pause_key = 1'b0;
    tick();
    pellets(1);
    check("pause_pellet_ignored", bus.pellets_left, 240);
    hit();
    tick();
    check("pause_hit_ignored", bus.lives, 3);
    frames(5);
    check("pause_holds", bus.game_state, 6);
    bus.pause_key = 1'b1;
    tick();
    check("unpause_no_restart_a", bus.actors_restart, 0);
    tick();
    check("unpause_state", bus.game_state, 2);
    check("unpause_no_restart_b", bus.actors_restart, 0);
    bus.pause_key = 1'b0;
    tick();
    check("unpause_play_on", bus.playGame, 1);
`else
    tick();
    check("pause_ignored_state", bus.game_state, 2);
    check("pause_ignored_play",  bus.playGame, 1);
    bus.pause_key = 1'b0;
    pellets(1);
    check("pause_ignored_pellet", bus.pellets_left, 239);
`endif

    // Reset mid-game with start held
    reset         = 1'b1;
    bus.start_key = 1'b1;
    tick();
    check("midrst_state",   bus.game_state, 0);
    check("midrst_restart", bus.actors_restart, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("held_key_no_start", bus.game_state, 0);
    release_start();
    tick();
    press_start();
    check("repress_ready", bus.game_state, 1);
    release_start();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the Pac-Man datapath. Owns the game state machine and drives the movers' playGame enable and a restart pulse that returns actors to their initial positions. Tracks lives, level and remaining pellets from collision and pellet events. Sits between the key interface, the collision/pellet logic, and the actor move blocks; all timing is in startOfFrame pulses (30 Hz).

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
READY_FRAMES, 60, startOfFrame pulses spent in READY before play
DEATH_FRAMES, 45, startOfFrame pulses spent in DYING
CLEAR_FRAMES, 60, startOfFrame pulses spent in LEVEL_CLEAR
PELLETS_TOTAL, 240, pellets per level (1..511)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
start_key  in  1  level-sensitive start key
pause_key  in  1  level-sensitive pause key (used only with GAME_PAUSE_EN)
ghost_hit  in  1  one-cycle pulse, Pac-Man/ghost collision
pellet_eaten  in  1  one-cycle pulse, pellet consumed
playGame  out  1  mover enable, high only in PLAY
actors_restart  out  1  one-cycle pulse, actors back to initial position/state
lives  out  3  remaining lives
level  out  4  current level, 1..15
pellets_left  out  9  pellets remaining this level
game_state  out  3  ATTRACT=0 READY=1 PLAY=2 DYING=3 LEVEL_CLEAR=4 GAME_OVER=5 PAUSED=6

Behaviour:
- One clock domain. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: state ATTRACT, playGame 0, actors_restart 0, lives 0, level 0, pellets_left 0, frame counter 0, key edge registers 0.
- Key edges: start_key and pause_key are each registered once. A rise is cur=1 and prev=0. A key held across reset does not produce a rise until it is released and pressed again.
- All outputs are registered. playGame is high in the cycle after the state register equals PLAY.
- Frame counter: cleared on every state entry. In a timed state (READY, DYING, LEVEL_CLEAR), each startOfFrame either exits the state when count equals N-1, or increments the count. The state is therefore left on the Nth startOfFrame after entry.
- ATTRACT: on a start rise, load lives=LIVES_INIT, level=1, pellets_left=PELLETS_TOTAL, then go to READY.
- READY: actors_restart pulses high for exactly one cycle on entry. After READY_FRAMES, go to PLAY.
- PLAY:
  - pellet_eaten decrements pellets_left, saturating at 0.
  - When a decrement takes pellets_left from 1 to 0, go to LEVEL_CLEAR.
  - Otherwise, ghost_hit decrements lives and goes to DYING.
  - If ghost_hit and the final pellet_eaten arrive in the same cycle, the pellet wins: LEVEL_CLEAR, lives unchanged.
  - ghost_hit and pellet_eaten are ignored in every state other than PLAY.
- DYING: after DEATH_FRAMES, go to GAME_OVER if lives==0, else to READY. pellets_left is preserved.
- LEVEL_CLEAR: after CLEAR_FRAMES, level increments (saturating at 15), pellets_left reloads to PELLETS_TOTAL, then go to READY.
- GAME_OVER: lives, level and pellets_left hold their values for display. A start rise goes to ATTRACT.
- Reset mid-game returns to ATTRACT immediately. No actors_restart pulse is issued on reset.
- startOfFrame and state entry in the same cycle: the pulse is not counted toward the new state.

Optional Feature:
GAME_PAUSE_EN
- Defined: in PLAY, a pause_key rise goes to PAUSED (playGame=0). All counters hold. Events are ignored while paused. A second rise returns to PLAY with no actors_restart pulse.
- Undefined: PAUSED is unreachable and pause_key is ignored. The port remains for a stable interface.

Test Plan:
- Reset then start_key rise (test overrides READY_FRAMES=4) -> state 1, single actors_restart pulse, lives=3, level=1, pellets_left=240. State 2 on the 4th startOfFrame. playGame=1 the next cycle.
- In PLAY, 240 pellet_eaten pulses -> pellets_left reaches 0, state 4. After CLEAR_FRAMES: level=2, pellets_left=240, state 1.
- In PLAY, ghost_hit with lives=1 -> lives=0, state 3, playGame=0. After DEATH_FRAMES: state 5, then a start rise goes to state 0.
- pellets_left=1, ghost_hit and pellet_eaten in the same cycle -> state 4, lives unchanged, pellets_left=0.
- start_key held high through reset release -> stays in ATTRACT. Release then press -> READY.
- GAME_PAUSE_EN defined, pause rise in PLAY -> state 6, pellet_eaten ignored (pellets_left unchanged). Second rise -> state 2, no actors_restart pulse.
